mem_bist: RTL

- Built-in self-test initiator for the small sel/wr register-file memory.
- Drives that memory's bus from the master side: walks all addresses, writes a pattern, reads back and compares.
- Repeats with the inverted pattern, then reports pass/fail, the first failing address and an error count.
- Sits beside the memory and shares its bus when test mode is selected; a mux outside this block handles that.

---
 rtl/mem_bist_if.sv | 26 ++
 rtl/mem_bist.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_bist_if.sv
// mem_bist_if -- sel/wr register-file memory bus.
//
// Purpose : bundles the request (sel, wr, addr, wdata) and the combinational
//           read-data return of the small register-file memory.
// Modports:
//   master : drives sel, wr, addr, wdata; receives rdata (the BIST side)
//   slave  : receives sel, wr, addr, wdata; drives rdata (the memory side)
// Signals :
//   sel    1       memory select
//   wr     1       1 = write, 0 = read (qualified by sel)
//   addr   ADDR_W  word address
//   wdata  DATA_W  write data
//   rdata  DATA_W  read data, valid in the same cycle as sel=1, wr=0
interface mem_bist_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 16
);
   logic              sel;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;

   modport master (output sel, output wr, output addr, output wdata, input rdata);
   modport slave  (input sel, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/mem_bist.sv
// mem_bist -- built-in self-test initiator for the sel/wr register-file memory.
//
// Purpose : walks addresses 0..DEPTH-1 writing D(0,a) = PATTERN ^ a, reads them
//           back and compares, then repeats with the inverted pattern
//           D(1,a) = ~D(0,a). Reports pass/fail, the first failing address and
//           a saturating mismatch count.
// Optional: define MEM_BIST_STOP_ON_FAIL_EN to end the run at the first read
//           mismatch (FSM goes straight to DONE on the next edge).
// Ports   :
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   start      in   begin a run (only sampled in IDLE)
//   busy       out  high during the four walk phases
//   done       out  one-cycle pulse when a run completes
//   pass       out  last run had no mismatches (held until next start)
//   fail_addr  out  address of the first mismatch in the last run
//   err_count  out  mismatch count of the last run, saturating
//   mem        master side of the memory bus (mem_bist_if)
module mem_bist #(
   parameter int                ADDR_W  = 2,
   parameter int                DATA_W  = 16,
   parameter int                DEPTH   = 4,
   parameter logic [DATA_W-1:0] PATTERN = 16'hA5A5,
   parameter int                ERR_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [ERR_W-1:0]  err_count,
   mem_bist_if.master        mem
);

   typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] cnt, cnt_n;
   logic              first_fail;
   logic              pass_q;
   logic              is_rd;
   logic              inv;
   logic [DATA_W-1:0] expected;
   logic              mismatch;

   function automatic logic [DATA_W-1:0] pattern_of(input logic invert,
                                                    input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      d = PATTERN ^ DATA_W'(a);
      return invert ? ~d : d;
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // next state and bus decode; bus outputs depend only on state and cnt
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      busy      = 1'b0;
      done      = 1'b0;
      is_rd     = 1'b0;
      inv       = 1'b0;
      mem.sel   = 1'b0;
      mem.wr    = 1'b0;
      mem.addr  = '0;
      mem.wdata = '0;

      case (state)
         IDLE: begin
            if (start) begin
               state_n = WR0;
               cnt_n   = '0;
            end
         end
         WR0, RD0, WR1, RD1: begin
            busy     = 1'b1;
            mem.sel  = 1'b1;
            mem.addr = cnt;
            inv      = (state == WR1) || (state == RD1);
            is_rd    = (state == RD0) || (state == RD1);
            if (!is_rd) begin
               mem.wr    = 1'b1;
               mem.wdata = pattern_of(inv, cnt);
            end
            if (cnt == ADDR_W'(DEPTH - 1)) begin
               cnt_n = '0;
               case (state)
                  WR0:     state_n = RD0;
                  RD0:     state_n = WR1;
                  WR1:     state_n = RD1;
                  default: state_n = DONE;
               endcase
            end else begin
               cnt_n = cnt + ADDR_W'(1);
            end
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      expected = pattern_of(inv, cnt);
      mismatch = is_rd && (mem.rdata != expected);

`ifdef MEM_BIST_STOP_ON_FAIL_EN
      if (mismatch) begin
         state_n = DONE;
         cnt_n   = '0;
      end
`endif
   end

   // result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count  <= '0;
         fail_addr  <= '0;
         first_fail <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            err_count  <= '0;
            fail_addr  <= '0;
            first_fail <= 1'b1;
            pass_q     <= 1'b0;
         end
         if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (first_fail) begin
               fail_addr  <= cnt;
               first_fail <= 1'b0;
            end
         end
         if (state == DONE)
            pass_q <= (err_count == '0);
      end
   end

   // err_count is final during DONE, so pass is valid in the done cycle itself
   assign pass = (state == DONE) ? (err_count == '0) : pass_q;

endmodule
